// File: rtl/stack_unit_pkg.sv
// Shared types and defaults for the stack unit.
// Holds the FSM state encoding and default geometry constants.
package stack_unit_pkg;
    localparam int STACK_DATA_W = 32;
    localparam int STACK_DEPTH  = 32;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } stack_state_e;
endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W flop array: one synchronous write port, two combinational reads.
// Reads are same-cycle (pre-edge contents); out-of-range addresses read as zero.
module stack_regfile
    import stack_unit_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  ra_top_i,
    input  logic [PTR_W-1:0]  ra_rd_i,
    output logic [DATA_W-1:0] rd_top_o,
    output logic [DATA_W-1:0] rd_rd_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i && (waddr_i < DEPTH_P)) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer arithmetic may wrap below zero; those addresses land >= DEPTH.
    assign rd_top_o = (ra_top_i < DEPTH_P) ? mem_q[ra_top_i[AW-1:0]] : '0;
    assign rd_rd_o  = (ra_rd_i  < DEPTH_P) ? mem_q[ra_rd_i[AW-1:0]]  : '0;
endmodule

// File: rtl/stack_unit.sv
// Hardware stack: push/pop with registered top, esp-relative read (1-cycle latency),
// sticky overflow/underflow, and a DEPTH-cycle clear sweep after reset or flush.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_off,
    input  logic              clear_err,
    output logic              busy,
    output logic [PTR_W-1:0]  esp,
    output logic [DATA_W-1:0] top_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] TWO_P   = PTR_W'(2);

    stack_state_e      state_q;
    logic [PTR_W-1:0]  clr_idx_q;
    logic [PTR_W-1:0]  esp_q;
    logic [DATA_W-1:0] top_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic              ovf_q;
    logic              unf_q;
    logic              busy_q;

    logic              is_full;
    logic              is_empty;
    logic              act;
    logic              op_push;
    logic              op_pop;
    logic              op_replace;
    logic              set_ovf;
    logic              set_unf;
    logic              rd_in_range;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [PTR_W-1:0]  ra_top;
    logic [PTR_W-1:0]  ra_rd;
    logic [DATA_W-1:0] mem_top;
    logic [DATA_W-1:0] mem_rd;

    always_comb begin
        is_full     = (esp_q == DEPTH_P);
        is_empty    = (esp_q == '0);
        act         = (state_q == IDLE) && !flush;
        // push+pop on an empty stack degrades to a plain push plus an underflow.
        op_push     = act && push && (pop ? is_empty : !is_full);
        op_replace  = act && push && pop && !is_empty;
        op_pop      = act && pop && !push && !is_empty;
        set_ovf     = act && push && !pop && is_full;
        set_unf     = act && pop && is_empty;
        rd_in_range = (rd_off < esp_q);
        ra_top      = esp_q - TWO_P;
        ra_rd       = esp_q - ONE_P - rd_off;

        we    = 1'b0;
        waddr = esp_q;
        wdata = push_data;
        if (state_q == SWEEP) begin
            we    = 1'b1;
            waddr = clr_idx_q;
            wdata = '0;
        end else if (op_replace) begin
            we    = 1'b1;
            waddr = esp_q - ONE_P;
        end else if (op_push) begin
            we    = 1'b1;
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clock    (clock),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .ra_top_i (ra_top),
        .ra_rd_i  (ra_rd),
        .rd_top_o (mem_top),
        .rd_rd_o  (mem_rd)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= SWEEP;
            clr_idx_q  <= '0;
            esp_q      <= '0;
            top_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            if ((state_q == IDLE) && rd_en) begin
                rd_valid_q <= 1'b1;
                rd_err_q   <= !rd_in_range;
                rd_data_q  <= rd_in_range ? mem_rd : '0;
            end

            ovf_q <= (ovf_q && !clear_err) || set_ovf;
            unf_q <= (unf_q && !clear_err) || set_unf;

            if (flush) begin
                state_q   <= SWEEP;
                clr_idx_q <= '0;
                esp_q     <= '0;
                top_q     <= '0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    SWEEP: begin
                        if (clr_idx_q == LAST_P) begin
                            state_q   <= IDLE;
                            clr_idx_q <= '0;
                            busy_q    <= 1'b0;
                        end else begin
                            clr_idx_q <= clr_idx_q + ONE_P;
                        end
                    end
                    IDLE: begin
                        if (op_push) begin
                            esp_q <= esp_q + ONE_P;
                            top_q <= push_data;
                        end else if (op_replace) begin
                            top_q <= push_data;
                        end else if (op_pop) begin
                            esp_q <= esp_q - ONE_P;
                            top_q <= (esp_q == ONE_P) ? '0 : mem_top;
                        end
                    end
                    default: state_q <= SWEEP;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign esp       = esp_q;
    assign top_data  = top_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit with DEPTH=4: vector table plus read scoreboard.
module tb_stack_unit;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int PW = 3;

    logic          clock = 1'b0;
    logic          reset, flush, push, pop, rd_en, clear_err;
    logic [DW-1:0] push_data;
    logic [PW-1:0] rd_off;
    logic          busy, full, empty, rd_valid, rd_err, overflow, underflow;
    logic [PW-1:0] esp;
    logic [DW-1:0] top_data, rd_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] data;
        logic          rd_en;
        logic [PW-1:0] off;
        logic          clr;
        int            e_esp;
        logic [DW-1:0] e_top;
        logic          e_ovf;
        logic          e_unf;
        logic [DW-1:0] e_rd;
        logic          e_err;
    } vec_t;

    vec_t            vecs [$];
    logic [DW:0]     sb   [$];

    stack_unit #(.DATA_W(DW), .DEPTH(DP), .PTR_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .rd_en     (rd_en),
        .rd_off    (rd_off),
        .clear_err (clear_err),
        .busy      (busy),
        .esp       (esp),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge, then check the read scoreboard against the read port.
    task automatic tick();
        logic [DW:0] e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_valid", {31'b0, rd_valid}, 32'd1);
            chk("rd_data", rd_data, e[DW-1:0]);
            chk("rd_err", {31'b0, rd_err}, {31'b0, e[DW]});
        end else begin
            chk("rd_valid_idle", {31'b0, rd_valid}, 32'd0);
        end
    endtask

    task automatic add(input logic pu, input logic po, input logic [DW-1:0] d,
                       input logic re, input logic [PW-1:0] off, input logic clr,
                       input int e_esp, input logic [DW-1:0] e_top,
                       input logic e_ovf, input logic e_unf,
                       input logic [DW-1:0] e_rd, input logic e_err);
        vec_t v;
        v.push = pu; v.pop = po; v.data = d; v.rd_en = re; v.off = off; v.clr = clr;
        v.e_esp = e_esp; v.e_top = e_top; v.e_ovf = e_ovf; v.e_unf = e_unf;
        v.e_rd = e_rd; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    // Hold push/pop/rd_en high through the sweep; none of them may take effect.
    task automatic wait_sweep();
        int cnt = 0;
        push = 1'b1; pop = 1'b1; rd_en = 1'b1; rd_off = '0; push_data = 32'hEE;
        do begin
            tick();
            cnt++;
        end while (busy && cnt < 50);
        push = 1'b0; pop = 1'b0; rd_en = 1'b0;
        chk("busy_len", 32'(cnt), 32'(DP));
        chk("sweep_esp", 32'(esp), 32'd0);
        chk("sweep_ovf", {31'b0, overflow}, 32'd0);
        chk("sweep_unf", {31'b0, underflow}, 32'd0);
        chk("sweep_empty", {31'b0, empty}, 32'd1);
        chk("sweep_top", top_data, 32'd0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; rd_en = 1'b0;
        clear_err = 1'b0; push_data = '0; rd_off = '0;

        //   push pop data   rd off clr  esp top    ovf unf  rd     err
        add(1, 0, 32'h11, 0, 0, 0,  1, 32'h11, 0, 0, 32'h0,  0);
        add(1, 0, 32'h22, 0, 0, 0,  2, 32'h22, 0, 0, 32'h0,  0);
        add(1, 0, 32'h33, 0, 0, 0,  3, 32'h33, 0, 0, 32'h0,  0);
        add(1, 0, 32'h44, 0, 0, 0,  4, 32'h44, 0, 0, 32'h0,  0);
        add(1, 0, 32'h55, 0, 0, 0,  4, 32'h44, 1, 0, 32'h0,  0);
        add(1, 0, 32'h66, 0, 0, 1,  4, 32'h44, 1, 0, 32'h0,  0);
        add(0, 0, 32'h00, 0, 0, 1,  4, 32'h44, 0, 0, 32'h0,  0);
        add(0, 1, 32'h00, 0, 0, 0,  3, 32'h33, 0, 0, 32'h0,  0);
        add(1, 1, 32'h99, 0, 0, 0,  3, 32'h99, 0, 0, 32'h0,  0);
        add(0, 1, 32'h00, 0, 0, 0,  2, 32'h22, 0, 0, 32'h0,  0);
        add(0, 1, 32'h00, 0, 0, 0,  1, 32'h11, 0, 0, 32'h0,  0);
        add(0, 1, 32'h00, 0, 0, 0,  0, 32'h00, 0, 0, 32'h0,  0);
        add(0, 1, 32'h00, 0, 0, 0,  0, 32'h00, 0, 1, 32'h0,  0);
        add(0, 0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 0, 32'h0,  0);
        add(1, 1, 32'h11, 0, 0, 0,  1, 32'h11, 0, 1, 32'h0,  0);
        add(1, 0, 32'h22, 0, 0, 1,  2, 32'h22, 0, 0, 32'h0,  0);
        add(1, 0, 32'h33, 0, 0, 0,  3, 32'h33, 0, 0, 32'h0,  0);
        add(0, 0, 32'h00, 1, 2, 0,  3, 32'h33, 0, 0, 32'h11, 0);
        add(0, 0, 32'h00, 1, 3, 0,  3, 32'h33, 0, 0, 32'h0,  1);
        add(1, 0, 32'h77, 1, 0, 0,  4, 32'h77, 0, 0, 32'h33, 0);
        add(0, 1, 32'h00, 1, 0, 0,  3, 32'h33, 0, 0, 32'h77, 0);
        add(1, 1, 32'h88, 1, 1, 0,  3, 32'h88, 0, 0, 32'h22, 0);
        add(0, 0, 32'h00, 1, 7, 0,  3, 32'h88, 0, 0, 32'h0,  1);
        add(0, 0, 32'h00, 0, 0, 0,  3, 32'h88, 0, 0, 32'h0,  0);

        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_esp", 32'(esp), 32'd0);
        chk("rst_top", top_data, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_rd_err", {31'b0, rd_err}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_unf", {31'b0, underflow}, 32'd0);

        reset = 1'b1;
        wait_sweep();

        foreach (vecs[i]) begin
            push = vecs[i].push; pop = vecs[i].pop; push_data = vecs[i].data;
            rd_en = vecs[i].rd_en; rd_off = vecs[i].off; clear_err = vecs[i].clr;
            if (vecs[i].rd_en) sb.push_back({vecs[i].e_err, vecs[i].e_rd});
            tick();
            push = 1'b0; pop = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
            chk($sformatf("v%0d_esp", i), 32'(esp), 32'(vecs[i].e_esp));
            chk($sformatf("v%0d_top", i), top_data, vecs[i].e_top);
            chk($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].e_ovf});
            chk($sformatf("v%0d_unf", i), {31'b0, underflow}, {31'b0, vecs[i].e_unf});
            chk($sformatf("v%0d_full", i), {31'b0, full}, {31'b0, vecs[i].e_esp == DP});
            chk($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, vecs[i].e_esp == 0});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
        end

        // Flush with a non-empty stack, then reset mid-sweep.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_esp", 32'(esp), 32'd0);
        chk("flush_top", top_data, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_busy", {31'b0, busy}, 32'd1);
        chk("midrst_esp", 32'(esp), 32'd0);
        wait_sweep();

        // Flush mid-sweep restarts the full DEPTH-cycle sweep.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_sweep();

        rd_en = 1'b1; rd_off = '0;
        sb.push_back({1'b1, 32'h0});
        tick();
        rd_en = 1'b0;
        chk("post_esp0", 32'(esp), 32'd0);
        push = 1'b1; push_data = 32'h12;
        tick();
        push = 1'b0;
        chk("post_push_esp", 32'(esp), 32'd1);
        chk("post_push_top", top_data, 32'h12);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("post_pop_esp", 32'(esp), 32'd0);
        chk("post_pop_top", top_data, 32'd0);
        chk("post_pop_unf", {31'b0, underflow}, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
